// File: rtl/seven_seg_scanner.sv
// Scan driver for a 4-digit multiplexed seven-segment display with double-buffered data.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data,
    output logic [3:0]  phase,
    output logic        an0,
    output logic        an1,
    output logic        an2,
    output logic        an3,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    phase_q, phase_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fdone_q;

    logic       tick;
    logic       wrap;
    logic [1:0] sel;
    logic       lit;
    logic [3:0] nib;
    logic       blank;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (cnt_q == LAST);
        wrap    = tick && (phase_q == 4'hF);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        phase_d = tick ? phase_q + 4'd1 : phase_q;

        // Wrap moves the old pending value first; a same-cycle load refills the buffer.
        disp_d     = (wrap && pend_vld_q) ? pend_q : disp_q;
        pend_d     = load ? data : pend_q;
        pend_vld_d = load ? 1'b1 : (wrap ? 1'b0 : pend_vld_q);
    end

    // Outputs are decoded from next-state values so pins stay aligned with phase.
    always_comb begin
        sel = phase_d[3:2];
        lit = (phase_d[1:0] == 2'b10);
        nib = disp_d[{sel, 2'b00} +: 4];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        unique case (sel)
            2'd3:    blank = (disp_d[15:12] == 4'h0);
            2'd2:    blank = (disp_d[15:8] == 8'h00);
            2'd1:    blank = (disp_d[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (lit && !blank) begin
            an_d[sel] = 1'b0;
            seg_d     = enc(nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            phase_q    <= 4'h0;
            disp_q     <= 16'h0000;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            fdone_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fdone_q    <= wrap;
        end
    end

    assign phase      = phase_q;
    assign an0        = an_q[0];
    assign an1        = an_q[1];
    assign an2        = an_q[2];
    assign an3        = an_q[3];
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = fdone_q;

endmodule
